// File: rtl/data_in_window_pkg.sv
// Shared constants for the SUBLEQ input delay window.
package data_in_window_pkg;

  localparam int unsigned WORD_SIZE = 16;
  localparam int unsigned DEPTH_MIN = 2;

endpackage

// File: rtl/data_window_stage.sv
// One window slot: a word/valid register pair with shift enable, sync clear and async reset.
module data_window_stage
  import data_in_window_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_SIZE
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             i_shift,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Clear wins over shift so a flushed cycle never captures the incoming word.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_clr) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_shift) begin
      r_data  <= i_data;
      r_valid <= i_valid;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/data_in_window.sv
// Input delay window: tap 0 is the live input, taps 1..DEPTH-1 hold earlier words,
// with fill tracking and a saturating accepted-word counter.
module data_in_window
  import data_in_window_pkg::*;
#(
  parameter int unsigned WIDTH       = WORD_SIZE,
  parameter int unsigned DEPTH       = 3,
  parameter bit          BUBBLE_MODE = 1'b0,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     areset_n,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     in_valid,
  input  logic                     flush,
  output logic [WIDTH*DEPTH-1:0]   taps,
  output logic [DEPTH-1:0]         tap_valid,
  output logic [$clog2(DEPTH)-1:0] fill_count,
  output logic                     full,
  output logic [CNT_WIDTH-1:0]     accepted
);

  localparam int unsigned FILL_W = $clog2(DEPTH);
  localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] ACC_MAX  = '1;

  if (DEPTH < DEPTH_MIN) begin : g_depth_chk
    $error("data_in_window: DEPTH must be at least 2");
  end

  logic [DEPTH-1:0][WIDTH-1:0] w_data;
  logic [DEPTH-1:0]            w_valid;
  logic                        w_shift;

  logic [FILL_W-1:0]    r_fill;
  logic                 r_full;
  logic [CNT_WIDTH-1:0] r_acc;
  logic [FILL_W-1:0]    w_fill_nxt;
  logic [CNT_WIDTH-1:0] w_acc_nxt;

  assign w_data[0]  = data_in;
  assign w_valid[0] = in_valid;
  assign w_shift    = BUBBLE_MODE ? 1'b1 : in_valid;

  // Shift chain: stage k takes the output of stage k-1.
  for (genvar k = 1; k < DEPTH; k++) begin : g_stage
    data_window_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .areset_n (areset_n),
      .i_shift  (w_shift),
      .i_clr    (flush),
      .i_data   (w_data[k-1]),
      .i_valid  (w_valid[k-1]),
      .o_data   (w_data[k]),
      .o_valid  (w_valid[k])
    );
  end

  assign taps      = w_data;
  assign tap_valid = w_valid;

  // Bubble mode tracks valids entering and leaving; compacting mode only counts up.
  always_comb begin
    w_fill_nxt = r_fill;
    w_acc_nxt  = r_acc;
    if (BUBBLE_MODE) begin
      w_fill_nxt = r_fill + FILL_W'(in_valid) - FILL_W'(w_valid[DEPTH-1]);
    end else if (in_valid && (r_fill != FILL_MAX)) begin
      w_fill_nxt = r_fill + FILL_W'(1);
    end
    if (in_valid && (r_acc != ACC_MAX)) begin
      w_acc_nxt = r_acc + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_fill <= '0;
      r_full <= 1'b0;
      r_acc  <= '0;
    end else if (flush) begin
      r_fill <= '0;
      r_full <= 1'b0;
      r_acc  <= '0;
    end else begin
      r_fill <= w_fill_nxt;
      r_full <= (w_fill_nxt == FILL_MAX);
      r_acc  <= w_acc_nxt;
    end
  end

  assign fill_count = r_fill;
  assign full       = r_full;
  assign accepted   = r_acc;

endmodule

// File: tb/tb_data_in_window.sv
// Bench for data_in_window: compacting and bubble instances driven in parallel,
// checked against a history-queue reference model.
module tb_data_in_window;

  localparam int unsigned W = 8;
  localparam int unsigned D = 3;
  localparam int unsigned C = 4;

  logic           clk = 1'b0;
  logic           areset_n;
  logic [W-1:0]   data_in;
  logic           in_valid;
  logic           flush;

  logic [W*D-1:0] taps_c, taps_b;
  logic [D-1:0]   tv_c, tv_b;
  logic [1:0]     fill_c, fill_b;
  logic           full_c, full_b;
  logic [C-1:0]   acc_c, acc_b;

  int n_cmp = 0;
  int n_err = 0;

  // Reference history: last accepted words (compacting) and last per-cycle {valid,data} (bubble).
  logic [W-1:0] qc[$];
  logic [W:0]   qb[$];
  int           acc_m = 0;

  data_in_window #(.WIDTH(W), .DEPTH(D), .BUBBLE_MODE(1'b0), .CNT_WIDTH(C)) u_cmp (
    .clk(clk), .areset_n(areset_n), .data_in(data_in), .in_valid(in_valid), .flush(flush),
    .taps(taps_c), .tap_valid(tv_c), .fill_count(fill_c), .full(full_c), .accepted(acc_c)
  );

  data_in_window #(.WIDTH(W), .DEPTH(D), .BUBBLE_MODE(1'b1), .CNT_WIDTH(C)) u_bub (
    .clk(clk), .areset_n(areset_n), .data_in(data_in), .in_valid(in_valid), .flush(flush),
    .taps(taps_b), .tap_valid(tv_b), .fill_count(fill_b), .full(full_b), .accepted(acc_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time (observed=timeout expected=finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    qc.delete();
    qb.delete();
    acc_m = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    if (!areset_n || flush) begin
      model_clear();
    end else begin
      if (in_valid) begin
        qc.push_back(data_in);
        if (qc.size() > D - 1) void'(qc.pop_front());
        if (acc_m < (1 << C) - 1) acc_m++;
      end
      qb.push_back({in_valid, data_in});
      if (qb.size() > D - 1) void'(qb.pop_front());
    end
  endtask

  task automatic check_all(input string tag);
    logic [W*D-1:0] et;
    logic [D-1:0]   ev;
    int n, fe;
    et = '0; ev = '0;
    et[W-1:0] = data_in; ev[0] = in_valid;
    n = qc.size();
    for (int k = 1; k < D; k++)
      if (n >= k) begin et[k*W +: W] = qc[n-k]; ev[k] = 1'b1; end
    fe = (n > D - 1) ? D - 1 : n;
    chk({tag, ".c_taps"}, 32'(taps_c), 32'(et));
    chk({tag, ".c_tv"},   32'(tv_c),   32'(ev));
    chk({tag, ".c_fill"}, 32'(fill_c), 32'(fe));
    chk({tag, ".c_full"}, 32'(full_c), 32'(fe == D - 1));
    chk({tag, ".c_acc"},  32'(acc_c),  32'(acc_m));
    et = '0; ev = '0;
    et[W-1:0] = data_in; ev[0] = in_valid;
    n = qb.size();
    fe = 0;
    for (int k = 1; k < D; k++)
      if (n >= k) begin
        et[k*W +: W] = qb[n-k][W-1:0];
        ev[k] = qb[n-k][W];
        fe += int'(qb[n-k][W]);
      end
    chk({tag, ".b_taps"}, 32'(taps_b), 32'(et));
    chk({tag, ".b_tv"},   32'(tv_b),   32'(ev));
    chk({tag, ".b_fill"}, 32'(fill_b), 32'(fe));
    chk({tag, ".b_full"}, 32'(full_b), 32'(fe == D - 1));
    chk({tag, ".b_acc"},  32'(acc_b),  32'(acc_m));
  endtask

  // Drive inputs just after a falling edge, then check one time unit later.
  task automatic drive(input logic [W-1:0] d, input logic v, input logic f, input string tag);
    data_in = d; in_valid = v; flush = f;
    #1;
    check_all(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    areset_n = 1'b0; data_in = 8'h5A; in_valid = 1'b1; flush = 1'b0;
    @(negedge clk);

    // Reset held with a valid word on the input
    drive(8'h5A, 1'b1, 1'b0, "rst");
    chk("rst.taps", 32'(taps_c), 32'h00005A);
    chk("rst.tv",   32'(tv_c),   32'b001);
    tick();
    drive(8'h5A, 1'b1, 1'b0, "rst2");
    areset_n = 1'b1;
    #1;

    // Compacting fill with an idle gap
    drive(8'h11, 1'b1, 1'b0, "cf0"); tick();
    drive(8'h00, 1'b0, 1'b0, "cf1"); tick();
    drive(8'h22, 1'b1, 1'b0, "cf2"); tick();
    drive(8'h33, 1'b1, 1'b0, "cf3");
    chk("cf.taps112233", 32'(taps_c), 32'h112233);
    tick();
    drive(8'h00, 1'b0, 1'b0, "cf4");
    chk("cf.full", 32'(full_c), 32'd1);
    chk("cf.acc3", 32'(acc_c),  32'd3);
    chk("cf.old",  32'(taps_c[23:8]), 32'h2233);
    tick();
    drive(8'h00, 1'b0, 1'b0, "cf5");
    chk("cf.idle_hold", 32'(taps_c[23:8]), 32'h2233);

    // Bubble: single valid word walks through the window
    drive(8'h00, 1'b0, 1'b1, "bf"); tick();
    drive(8'hAA, 1'b1, 1'b0, "b0"); tick();
    drive(8'h00, 1'b0, 1'b0, "b1");
    chk("b.fill1", 32'(fill_b), 32'd1);
    chk("b.tap1",  32'(taps_b[15:8]), 32'hAA);
    tick();
    drive(8'h00, 1'b0, 1'b0, "b2");
    chk("b.fill1b", 32'(fill_b), 32'd1);
    chk("b.tap2",   32'(taps_b[23:16]), 32'hAA);
    chk("b.v2",     32'(tv_b), 32'b100);
    chk("b.nofull", 32'(full_b), 32'd0);
    tick();
    drive(8'h00, 1'b0, 1'b0, "b3");
    chk("b.fill0", 32'(fill_b), 32'd0);

    // Flush while a valid word is presented
    drive(8'h01, 1'b1, 1'b0, "fl0"); tick();
    drive(8'h02, 1'b1, 1'b0, "fl1"); tick();
    drive(8'h03, 1'b1, 1'b0, "fl2"); tick();
    drive(8'h44, 1'b1, 1'b1, "fl3"); tick();
    drive(8'h00, 1'b0, 1'b0, "fl4");
    chk("fl.tv",   32'(tv_c),   32'b000);
    chk("fl.fill", 32'(fill_c), 32'd0);
    chk("fl.acc",  32'(acc_c),  32'd0);
    chk("fl.taps", 32'(taps_c), 32'h000000);

    // Saturation of the accepted counter
    for (int i = 0; i < 20; i++) begin
      drive(8'($urandom), 1'b1, 1'b0, "sat");
      tick();
    end
    drive(8'h00, 1'b0, 1'b0, "sat_end");
    chk("sat.acc15", 32'(acc_c),  32'd15);
    chk("sat.fill2", 32'(fill_c), 32'd2);

    // Asynchronous reset between edges with the window full
    drive(8'h77, 1'b1, 1'b0, "mr0");
    #1 areset_n = 1'b0;
    model_clear();
    #1;
    check_all("mr1");
    chk("mr.full", 32'(full_c), 32'd0);
    chk("mr.acc",  32'(acc_c),  32'd0);
    tick();
    drive(8'h00, 1'b0, 1'b0, "mr2");
    areset_n = 1'b1;
    #1;
    drive(8'h11, 1'b1, 1'b0, "rf0"); tick();
    drive(8'h00, 1'b0, 1'b0, "rf1"); tick();
    drive(8'h22, 1'b1, 1'b0, "rf2"); tick();
    drive(8'h33, 1'b1, 1'b0, "rf3");
    chk("rf.taps112233", 32'(taps_c), 32'h112233);
    tick();
    drive(8'h00, 1'b0, 1'b0, "rf4");
    chk("rf.acc3", 32'(acc_c), 32'd3);

    // Randomised traffic with occasional flush and mid-cycle reset pulses
    for (int i = 0; i < 400; i++) begin
      drive(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), "rnd");
      if ($urandom_range(0, 31) == 0) begin
        #1 areset_n = 1'b0;
        model_clear();
        #1;
        check_all("rnd_rst");
        areset_n = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
